// File: rtl/inv_broadcast_queue_pkg.sv
// Shared types and defaults for the instruction invalidation broadcast queue.
// Coalescing of repeated requests is enabled by defining INV_QUEUE_COALESCE_EN.
package cva5_types;
    localparam int INV_ADDR_W = 30;
    localparam int INV_QUEUE_DEPTH_DEFAULT = 4;
    localparam int INV_QUEUE_SINKS_DEFAULT = 2;

    typedef logic [INV_ADDR_W-1:0] inv_addr_t;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int inv_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/inv_broadcast_queue_ack_tracker.sv
// Per-sink acceptance tracking for the head entry of the invalidation queue.
// Raises retire once every sink has taken the head, and then clears the mask for the next entry.
module inv_ack_tracker #(
    parameter int NUM_SINKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active_i,
    input  logic [NUM_SINKS-1:0] sink_ready_i,
    output logic [NUM_SINKS-1:0] sink_valid_o,
    output logic                 retire_o
);
    localparam int NS = NUM_SINKS;
    typedef logic [NS-1:0] sink_mask_t;

    sink_mask_t ack_q;
    sink_mask_t ack_d;
    sink_mask_t handshake;

    // A sink that has already taken the head sees valid low until the next entry arrives.
    always_comb begin
        sink_valid_o = active_i ? ~ack_q : '0;
        handshake    = sink_valid_o & sink_ready_i;
        retire_o     = active_i & (&(ack_q | handshake));
        ack_d        = retire_o ? '0 : (ack_q | handshake);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= '0;
        end else begin
            ack_q <= ack_d;
        end
    end
endmodule

// File: rtl/inv_broadcast_queue.sv
// Queued fan-out of instruction invalidations from one source to NUM_SINKS consumers.
// Defining INV_QUEUE_COALESCE_EN merges a request matching the newest not-yet-broadcast entry.
module inv_broadcast_queue
    import cva5_types::*;
#(
    parameter int DEPTH     = INV_QUEUE_DEPTH_DEFAULT,
    parameter int NUM_SINKS = INV_QUEUE_SINKS_DEFAULT,
    parameter int ADDR_W    = INV_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    src_inv_addr,
    input  logic                 src_inv_valid,
    output logic                 src_inv_ready,
    output logic                 inv_completed,
    output logic                 inv_outstanding,
    output logic                 coalesced,
    output logic [ADDR_W-1:0]    sink_inv_addr,
    output logic [NUM_SINKS-1:0] sink_inv_valid,
    input  logic [NUM_SINKS-1:0] sink_inv_ready,
    input  logic [NUM_SINKS-1:0] sink_inv_outstanding
);
    localparam int PTR_W = inv_ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam int NS    = NUM_SINKS;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [NS-1:0]    sink_mask_t;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic              completed_q;
    logic              empty, full, write_en, retire, hit;
    sink_mask_t        sink_valid;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    inv_ack_tracker #(
        .NUM_SINKS(NUM_SINKS)
    ) u_ack_tracker (
        .clk         (clk),
        .rst         (rst),
        .active_i    (!empty),
        .sink_ready_i(sink_inv_ready),
        .sink_valid_o(sink_valid),
        .retire_o    (retire)
    );

`ifdef INV_QUEUE_COALESCE_EN
    ptr_t last_ptr;
    logic last_is_head;
    logic head_untouched;
    logic coalesced_q;

    // The newest entry may absorb a repeat only while no sink has started taking it.
    always_comb begin
        last_ptr       = wr_ptr_q - ptr_t'(1);
        last_is_head   = (last_ptr == rd_ptr_q);
        head_untouched = (&sink_valid) & !(|(sink_valid & sink_inv_ready));
        hit            = src_inv_valid & !empty &
                         (mem_q[last_ptr[IDX_W-1:0]] == src_inv_addr) &
                         (!last_is_head | head_untouched);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coalesced_q <= 1'b0;
        end else begin
            coalesced_q <= hit;
        end
    end

    assign coalesced = coalesced_q;
`else
    assign hit       = 1'b0;
    assign coalesced = 1'b0;
`endif

    // Readiness depends only on registered occupancy, so a same-cycle retire never frees a slot early.
    always_comb begin
        src_inv_ready = !full | hit;
        write_en      = src_inv_valid & !full & !hit;
        wr_ptr_d      = wr_ptr_q + ptr_t'(write_en);
        rd_ptr_d      = rd_ptr_q + ptr_t'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            completed_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            completed_q <= retire;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= src_inv_addr;
        end
    end

    assign sink_inv_addr   = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign sink_inv_valid  = sink_valid;
    assign inv_completed   = completed_q;
    assign inv_outstanding = !empty | (|sink_inv_outstanding);
endmodule

// File: tb/tb_inv_broadcast_queue.sv
// Self-checking bench for inv_broadcast_queue: directed vectors, corner sequences and a randomized queue model.
// Expectations follow INV_QUEUE_COALESCE_EN when it is defined for the build.
module tb_inv_broadcast_queue;
    localparam int DEPTH = 4;
    localparam int NS    = 2;
    localparam int AW    = 30;

`ifdef INV_QUEUE_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] src_inv_addr = '0;
    logic          src_inv_valid = 1'b0;
    logic          src_inv_ready;
    logic          inv_completed;
    logic          inv_outstanding;
    logic          coalesced;
    logic [AW-1:0] sink_inv_addr;
    logic [NS-1:0] sink_inv_valid;
    logic [NS-1:0] sink_inv_ready = '0;
    logic [NS-1:0] sink_inv_outstanding = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_broadcast_queue #(
        .DEPTH(DEPTH),
        .NUM_SINKS(NS),
        .ADDR_W(AW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_inv_addr        (src_inv_addr),
        .src_inv_valid       (src_inv_valid),
        .src_inv_ready       (src_inv_ready),
        .inv_completed       (inv_completed),
        .inv_outstanding     (inv_outstanding),
        .coalesced           (coalesced),
        .sink_inv_addr       (sink_inv_addr),
        .sink_inv_valid      (sink_inv_valid),
        .sink_inv_ready      (sink_inv_ready),
        .sink_inv_outstanding(sink_inv_outstanding)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [NS-1:0] rdy;
        logic [NS-1:0] so;
        logic [NS-1:0] e_sv;
        logic [AW-1:0] e_addr;
        logic          e_comp;
        logic          e_out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic [NS-1:0] rdy,
                                input logic [NS-1:0] so, input logic [NS-1:0] e_sv,
                                input logic [AW-1:0] e_addr, input logic e_comp, input logic e_out);
        vec_t r;
        r.v = v; r.a = a; r.rdy = rdy; r.so = so;
        r.e_sv = e_sv; r.e_addr = e_addr; r.e_comp = e_comp; r.e_out = e_out;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the next rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [AW-1:0] a,
                                 input logic [NS-1:0] rdy, input logic [NS-1:0] so);
        @(negedge clk);
        rst                  = r;
        src_inv_valid        = v;
        src_inv_addr         = a;
        sink_inv_ready       = rdy;
        sink_inv_outstanding = so;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    logic [AW-1:0] mq[$];
    logic [NS-1:0] macked;
    logic          exp_comp, exp_coal;

    initial begin
        int pending, got_n, comp_n, coal_n;

        // Reset state
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        checkOutput("rst_ready",  32'(src_inv_ready),   32'd1);
        checkOutput("rst_valid",  32'(sink_inv_valid),  32'd0);
        checkOutput("rst_comp",   32'(inv_completed),   32'd0);
        checkOutput("rst_coal",   32'(coalesced),       32'd0);
        checkOutput("rst_outst",  32'(inv_outstanding), 32'd0);

        // Single push with both sinks ready, staggered acceptance, and the sink-outstanding hold
        vecs.push_back(mk(1, 30'h1000, 2'b00, 2'b00, 2'b00, 30'h0,    0, 0));
        vecs.push_back(mk(0, 30'h0,    2'b11, 2'b00, 2'b11, 30'h1000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b00, 30'h0,    1, 0));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b00, 30'h0,    0, 0));
        vecs.push_back(mk(1, 30'h2000, 2'b00, 2'b00, 2'b00, 30'h0,    0, 0));
        vecs.push_back(mk(0, 30'h0,    2'b01, 2'b00, 2'b11, 30'h2000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b10, 30'h2000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b10, 30'h2000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b10, 2'b00, 2'b10, 30'h2000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b00, 30'h0,    1, 0));
        vecs.push_back(mk(1, 30'h3000, 2'b00, 2'b00, 2'b00, 30'h0,    0, 0));
        vecs.push_back(mk(0, 30'h0,    2'b11, 2'b00, 2'b11, 30'h3000, 0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b01, 2'b00, 30'h0,    1, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b01, 2'b00, 30'h0,    0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b01, 2'b00, 30'h0,    0, 1));
        vecs.push_back(mk(0, 30'h0,    2'b11, 2'b00, 2'b00, 30'h0,    0, 0));
        vecs.push_back(mk(0, 30'h0,    2'b00, 2'b00, 2'b00, 30'h0,    0, 0));

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].v, vecs[i].a, vecs[i].rdy, vecs[i].so);
            checkOutput($sformatf("vec%0d_ready", i), 32'(src_inv_ready),   32'd1);
            checkOutput($sformatf("vec%0d_valid", i), 32'(sink_inv_valid),  32'(vecs[i].e_sv));
            checkOutput($sformatf("vec%0d_comp", i),  32'(inv_completed),   32'(vecs[i].e_comp));
            checkOutput($sformatf("vec%0d_outst", i), 32'(inv_outstanding), 32'(vecs[i].e_out));
            checkOutput($sformatf("vec%0d_coal", i),  32'(coalesced),       32'd0);
            if (vecs[i].e_sv != '0)
                checkOutput($sformatf("vec%0d_addr", i), 32'(sink_inv_addr), 32'(vecs[i].e_addr));
        end

        // Fill to full, then release the sinks with a fifth push pending
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, AW'(32'h10 + 32'(i)), 2'b00, 2'b00);
            checkOutput("fill_ready", 32'(src_inv_ready), 32'd1);
        end
        pending = 1; got_n = 0; comp_n = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, pending != 0, 30'h14, 2'b11, 2'b00);
            if (c == 0) checkOutput("full_ready", 32'(src_inv_ready), 32'd0);
            if (c == 1) checkOutput("ready_after_retire", 32'(src_inv_ready), 32'd1);
            if (sink_inv_valid == 2'b11) begin
                checkOutput("wrap_order", 32'(sink_inv_addr), 32'h10 + 32'(got_n));
                got_n++;
            end
            comp_n += int'(inv_completed);
            if (pending != 0 && src_inv_ready) pending = 0;
        end
        checkOutput("wrap_delivered", 32'(got_n), 32'd5);
        checkOutput("wrap_completed", 32'(comp_n), 32'd5);
        checkOutput("wrap_accepted", 32'(pending), 32'd0);

        // Reset mid-broadcast with sink0 already acked
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, AW'(32'h20 + 32'(i)), 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b0, '0, 2'b01, 2'b00);
        checkOutput("mid_valid_pre", 32'(sink_inv_valid), 32'h3);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("mid_valid_acked", 32'(sink_inv_valid), 32'h2);
        applyStimulus(1'b1, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("mid_rst_valid", 32'(sink_inv_valid), 32'h0);
        checkOutput("mid_rst_ready", 32'(src_inv_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b00);
        checkOutput("post_rst_outst", 32'(inv_outstanding), 32'd0);
        checkOutput("post_rst_ready", 32'(src_inv_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(sink_inv_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
        checkOutput("post_rst_comp", 32'(inv_completed), 32'd0);

        // Repeat address on the tail entry
        applyStimulus(1'b0, 1'b1, 30'h40, 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b1, 30'h50, 2'b00, 2'b00);
        applyStimulus(1'b0, 1'b1, 30'h50, 2'b00, 2'b00);
        checkOutput("dup_ready", 32'(src_inv_ready), 32'd1);
        comp_n = 0; coal_n = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b00);
            if (c == 0) checkOutput("dup_coalesced", 32'(coalesced), 32'(COALESCE));
            comp_n += int'(inv_completed);
            coal_n += int'(coalesced);
        end
        checkOutput("dup_completed", 32'(comp_n), COALESCE ? 32'd2 : 32'd3);
        checkOutput("dup_coal_count", 32'(coal_n), COALESCE ? 32'd1 : 32'd0);
        checkOutput("dup_drained", 32'(inv_outstanding), 32'd0);

        // Randomized traffic against a queue-level model
        mq.delete();
        macked = '0; exp_comp = 1'b0; exp_coal = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic          v, ne, full, hitm, retire;
            logic [AW-1:0] a;
            logic [NS-1:0] rdy, so, esv, hs;
            v   = ($urandom_range(0, 2) != 0);
            a   = AW'(32'h100 + $urandom_range(0, 2));
            rdy = NS'($urandom);
            so  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            applyStimulus(1'b0, v, a, rdy, so);

            ne   = (mq.size() > 0);
            full = (mq.size() == DEPTH);
            esv  = ne ? ~macked : '0;
            hs   = esv & rdy;
            hitm = COALESCE && v && ne && (a == mq[mq.size()-1]) &&
                   (mq.size() > 1 || (macked == '0 && hs == '0));

            checkOutput("rnd_ready", 32'(src_inv_ready),   32'(!full || hitm));
            checkOutput("rnd_valid", 32'(sink_inv_valid),  32'(esv));
            checkOutput("rnd_comp",  32'(inv_completed),   32'(exp_comp));
            checkOutput("rnd_coal",  32'(coalesced),       32'(exp_coal));
            checkOutput("rnd_outst", 32'(inv_outstanding), 32'(ne || (so != '0)));
            if (ne) checkOutput("rnd_addr", 32'(sink_inv_addr), 32'(mq[0]));

            retire   = ne && ((macked | hs) == '1);
            exp_comp = retire;
            exp_coal = hitm;
            if (retire) begin
                void'(mq.pop_front());
                macked = '0;
            end else begin
                macked = macked | hs;
            end
            if (v && !full && !hitm) mq.push_back(a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
